// File: rtl/ps2_teclado_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_teclado_ctrl
//
// PS/2 keyboard receive sequencer. Oversamples the raw PS/2 clock/data pins in
// the clk domain, frames each 11-bit packet (start, 8 data LSB first, odd
// parity, stop), and folds the E0 (extended) and F0 (break) prefixes into one
// decoded key event. 'carga' drives the load enable of the downstream general
// register so only make codes reach the display path.
//
// Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity. When it
// is not defined the parity bit is consumed but ignored.
//
// Parameters:
//   TIMEOUT_CYC  watchdog, in clk cycles, between PS/2 falling edges (>= 16)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clkps      in   raw PS/2 clock pin (asynchronous)
//   Rx         in   raw PS/2 data pin (asynchronous)
//   codigo     out  last decoded scan code, prefixes stripped
//   extendido  out  event was preceded by E0
//   liberado   out  event was preceded by F0 (key release)
//   valido     out  one-cycle event strobe
//   carga      out  one-cycle register load strobe (valido & ~liberado)
//   error      out  one-cycle frame error strobe (parity, stop, timeout)
//   ocupado    out  high while a frame is in progress
// -----------------------------------------------------------------------------
module ps2_teclado_ctrl #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clkps,
    input  logic       Rx,
    output logic [7:0] codigo,
    output logic       extendido,
    output logic       liberado,
    output logic       valido,
    output logic       carga,
    output logic       error,
    output logic       ocupado
);

    localparam int             WDW    = $clog2(TIMEOUT_CYC);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     PFX_E0 = 8'hE0;
    localparam logic [7:0]     PFX_F0 = 8'hF0;

    typedef enum logic [1:0] {REPOSO, DATOS, PARIDAD, PARADA} estado_t;

    estado_t        state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [WDW-1:0] wdog;
    logic           pend_e0;
    logic           pend_f0;

    logic clkps_s1, clkps_s2, clkps_prev;
    logic rx_s1, rx_s2;
    logic fall;
    logic frame_ok;

    // Synchronizers and edge detector idle at 1 so that a bus held high out of
    // reset never looks like a falling edge.
    // NOTE: every register here, including the data path, is reset; this block
    // is small enough that a fully known post-reset state costs nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkps_s1   <= 1'b1;
            clkps_s2   <= 1'b1;
            clkps_prev <= 1'b1;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments give each flop the value its
            // predecessor held before this edge, which is what makes a chain.
            clkps_s1   <= clkps;
            clkps_s2   <= clkps_s1;
            clkps_prev <= clkps_s2;
            rx_s1      <= Rx;
            rx_s2      <= rx_s1;
        end
    end

    assign fall = clkps_prev & ~clkps_s2;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    // Odd parity: data XOR parity must be 1; stop bit (current rx) must be 1.
    assign frame_ok = rx_s2 & (^{shreg, par_bit});
`else
    assign frame_ok = rx_s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= REPOSO;
            bit_cnt   <= '0;
            shreg     <= '0;
            wdog      <= '0;
            pend_e0   <= 1'b0;
            pend_f0   <= 1'b0;
            codigo    <= '0;
            extendido <= 1'b0;
            liberado  <= 1'b0;
            valido    <= 1'b0;
            carga     <= 1'b0;
            error     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            valido <= 1'b0;
            carga  <= 1'b0;
            error  <= 1'b0;

            // A falling edge always takes priority over a coincident watchdog
            // expiry: the edge restarts the window.
            if (fall) begin
                wdog <= '0;
                unique case (state)
                    REPOSO: begin
                        if (!rx_s2) begin
                            state   <= DATOS;
                            bit_cnt <= '0;
                        end
                    end
                    DATOS: begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARIDAD;
                    end
                    PARIDAD: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit <= rx_s2;
`endif
                        state <= PARADA;
                    end
                    PARADA: begin
                        state <= REPOSO;
                        if (!frame_ok) begin
                            // A corrupted byte may have been a prefix; drop
                            // any pending prefixes so they cannot attach to
                            // an unrelated later code.
                            error   <= 1'b1;
                            pend_e0 <= 1'b0;
                            pend_f0 <= 1'b0;
                        end else if (shreg == PFX_E0) begin
                            pend_e0 <= 1'b1;
                        end else if (shreg == PFX_F0) begin
                            pend_f0 <= 1'b1;
                        end else begin
                            codigo    <= shreg;
                            extendido <= pend_e0;
                            liberado  <= pend_f0;
                            valido    <= 1'b1;
                            carga     <= ~pend_f0;
                            pend_e0   <= 1'b0;
                            pend_f0   <= 1'b0;
                        end
                    end
                    default: state <= REPOSO;
                endcase
            end else if (state != REPOSO) begin
                if (wdog == WD_MAX) begin
                    error   <= 1'b1;
                    state   <= REPOSO;
                    wdog    <= '0;
                    pend_e0 <= 1'b0;
                    pend_f0 <= 1'b0;
                end else begin
                    wdog <= wdog + WDW'(1);
                end
            end
        end
    end

    assign ocupado = (state != REPOSO);

endmodule

// File: tb/tb_ps2_teclado_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ps2_teclado_ctrl
//
// Self-checking bench for ps2_teclado_ctrl. Drives PS/2 frames on clkps/Rx,
// records every valido/error pulse with its cycle stamp, and compares against
// a frame-level reference model of the prefix rules. Honors
// PS2_PARITY_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_teclado_ctrl;

    localparam int TO = 64;

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clkps;
    logic       Rx;
    logic [7:0] codigo;
    logic       extendido, liberado, valido, carga, error, ocupado;

    ps2_teclado_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clkps     (clkps),
        .Rx        (Rx),
        .codigo    (codigo),
        .extendido (extendido),
        .liberado  (liberado),
        .valido    (valido),
        .carga     (carga),
        .error     (error),
        .ocupado   (ocupado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       lib;
        logic       ld;
        int         cyc;
    } ev_t;

    ev_t evq[$];
    int  errq[$];
    int  cyc = 0;
    int  collide = 0;
    int  total = 0;
    int  bad = 0;
    int  hp = 6;
    int  fall_cyc = 0;

    // Reference model state: pending prefixes and the held output values.
    bit         m_e0 = 1'b0, m_f0 = 1'b0;
    logic [7:0] h_code = 8'h00;
    logic       h_ext = 1'b0, h_lib = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valido) evq.push_back('{codigo, extendido, liberado, carga, cyc});
        if (error) errq.push_back(cyc);
        if (valido && error) collide++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set up while clkps is high, then a low phase.
    // fall_cyc is the cycle stamp of the first clk edge that sees the pin low.
    task automatic ps2_bit(input logic b);
        Rx = b;
        tick(hp);
        clkps = 1'b0;
        fall_cyc = cyc + 1;
        tick(hp);
        clkps = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(~bad_stop);
        Rx = 1'b1;
        tick(4);
    endtask

    // Send one frame and check the outcome the prefix rules predict.
    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        bit   is_bad;
        int   stop_cyc;
        ev_t  e;
        send_frame(b, bad_par, bad_stop);
        stop_cyc = fall_cyc;
        is_bad = bad_stop || (PAR_EN && bad_par);
        if (is_bad) begin
            m_e0 = 1'b0;
            m_f0 = 1'b0;
            chk({tag, " err count"}, errq.size(), 1);
            chk({tag, " ev count"}, evq.size(), 0);
            if (errq.size() == 1) chk({tag, " err latency"}, errq[0], stop_cyc + 2);
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (b == 8'hE0) m_e0 = 1'b1;
            else            m_f0 = 1'b1;
            chk({tag, " prefix ev count"}, evq.size(), 0);
            chk({tag, " prefix err count"}, errq.size(), 0);
        end else begin
            h_code = b;
            h_ext  = m_e0;
            h_lib  = m_f0;
            m_e0   = 1'b0;
            m_f0   = 1'b0;
            chk({tag, " ev count"}, evq.size(), 1);
            chk({tag, " err count"}, errq.size(), 0);
            if (evq.size() == 1) begin
                e = evq[0];
                chk({tag, " ev code/ext/lib/carga"}, {e.code, e.ext, e.lib, e.ld},
                    {h_code, h_ext, h_lib, ~h_lib});
                chk({tag, " ev latency"}, e.cyc, stop_cyc + 2);
            end
        end
        chk({tag, " held outputs"}, {codigo, extendido, liberado}, {h_code, h_ext, h_lib});
        chk({tag, " ocupado idle"}, ocupado, 1'b0);
        evq.delete();
        errq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int stop_cyc;
        int waited;
        logic [7:0] rb;
        int sel;

        rst_n = 1'b0;
        clkps = 1'b1;
        Rx    = 1'b1;
        tick(3);
        chk("reset outputs", {codigo, extendido, liberado, valido, carga, error, ocupado}, 14'h0);
        rst_n = 1'b1;
        tick(4);

        // 1: plain make code
        do_frame("t1 1C", 8'h1C, 1'b0, 1'b0);

        // 2: break code
        do_frame("t2 F0", 8'hF0, 1'b0, 1'b0);
        do_frame("t2 1C", 8'h1C, 1'b0, 1'b0);

        // 3: extended make and extended break
        do_frame("t3 E0", 8'hE0, 1'b0, 1'b0);
        do_frame("t3 75", 8'h75, 1'b0, 1'b0);
        do_frame("t3 E0b", 8'hE0, 1'b0, 1'b0);
        do_frame("t3 F0b", 8'hF0, 1'b0, 1'b0);
        do_frame("t3 75b", 8'h75, 1'b0, 1'b0);

        // 4: bad parity; then a release still decodes
        do_frame("t4 1C badpar", 8'h1C, 1'b1, 1'b0);
        do_frame("t4 F0", 8'hF0, 1'b0, 1'b0);
        do_frame("t4 1C", 8'h1C, 1'b0, 1'b0);

        // 5: partial frame after a pending F0, then watchdog expiry
        do_frame("t5 F0", 8'hF0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        stop_cyc = fall_cyc;
        chk("t5 ocupado mid-frame", ocupado, 1'b1);
        waited = 0;
        while (errq.size() == 0 && waited < TO + 40) begin
            tick(1);
            waited++;
        end
        chk("t5 timeout err count", errq.size(), 1);
        if (errq.size() == 1) chk("t5 timeout latency", errq[0], stop_cyc + 2 + TO);
        chk("t5 timeout no event", evq.size(), 0);
        tick(2);
        chk("t5 ocupado after timeout", ocupado, 1'b0);
        m_e0 = 1'b0;
        m_f0 = 1'b0;
        evq.delete();
        errq.delete();
        do_frame("t5 29", 8'h29, 1'b0, 1'b0);

        // 6: reset mid-frame after a pending E0
        do_frame("t6 E0", 8'hE0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(rb_bit(8'h16, i));
        rst_n = 1'b0;
        tick(2);
        chk("t6 outputs in reset", {codigo, extendido, liberado, valido, carga, error, ocupado}, 14'h0);
        clkps = 1'b1;
        Rx    = 1'b1;
        rst_n = 1'b1;
        tick(TO + 10);
        chk("t6 no error after reset", errq.size(), 0);
        chk("t6 no event after reset", evq.size(), 0);
        m_e0 = 1'b0;
        m_f0 = 1'b0;
        h_code = 8'h00;
        h_ext = 1'b0;
        h_lib = 1'b0;
        do_frame("t6 16", 8'h16, 1'b0, 1'b0);
        do_frame("t6 16 badstop", 8'h16, 1'b0, 1'b1);

        // Randomized frames with random PS/2 clock rate
        for (int n = 0; n < 40; n++) begin
            hp  = int'($urandom_range(4, 10));
            sel = int'($urandom_range(0, 99));
            rb  = 8'($urandom);
            if (sel < 20)      rb = 8'hE0;
            else if (sel < 35) rb = 8'hF0;
            do_frame("rand", rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
        end

        chk("valido/error never together", collide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic rb_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/ps2_teclado_ctrl.md
# ps2_teclado_ctrl

Sequencing controller for the PS/2 keyboard receive path. It oversamples the raw PS/2 clock and data lines in the system clock domain, frames each 11-bit PS/2 packet, and resolves the `E0` (extended) and `F0` (break) prefixes into a single decoded key event. It drives the load enable of the downstream general register, so that only make codes reach the 7-segment / LED display path.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 100000: frame watchdog, in `clk` cycles, between successive PS/2 falling edges (2 ms at 50 MHz); minimum 16.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clkps`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `Rx`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `codigo`  out  8  last decoded scan code (prefixes stripped).
- `extendido`  out  1  event was preceded by `E0`.
- `liberado`  out  1  event was preceded by `F0` (key release).
- `valido`  out  1  one-cycle pulse; `codigo`, `extendido` and `liberado` are updated in the same cycle.
- `carga`  out  1  register load enable; one-cycle pulse equal to `valido & ~liberado`.
- `error`  out  1  one-cycle pulse on a frame error (parity, stop bit, or timeout).
- `ocupado`  out  1  high while a frame is being received.

## Operation

**Input conditioning**
- `clkps` and `Rx` each pass through a 2-flop synchronizer.
- A falling edge is detected when the previous synchronized `clkps` is 1 and the current one is 0.
- All data sampling happens only on a detected falling edge.

**Frame FSM** (states `REPOSO`, `DATOS`, `PARIDAD`, `PARADA`)
- `REPOSO`:
  - Falling edge with synced `Rx`=0: go to `DATOS` and clear the bit counter.
  - Falling edge with `Rx`=1: ignored, no error.
- `DATOS`: 8 falling edges; data is shifted in LSB first. Go to `PARIDAD` after the 8th bit.
- `PARIDAD`: sample the parity bit; the XOR of 8 data bits and the parity bit must equal 1 (odd parity). Go to `PARADA`.
- `PARADA`: sample the stop bit, which must be 1. Then:
  - Frame good: hand the byte to the prefix logic and return to `REPOSO`.
  - Frame bad: pulse `error`, discard the byte, clear both prefix flags, and return to `REPOSO`.
- Watchdog:
  - The counter clears on every falling edge and counts while the state is not `REPOSO`.
  - At `TIMEOUT_CYC-1`: pulse `error`, go to `REPOSO`, discard the partial frame, and clear the prefix flags.
- `ocupado` = (state != `REPOSO`).

**Prefix logic** (flags `pend_e0`, `pend_f0`)
- Byte `E0`: set `pend_e0`; no event.
- Byte `F0`: set `pend_f0`; no event.
- Repeated prefixes are idempotent.
- Any other byte:
  - Register `codigo` = byte, `extendido` = `pend_e0`, `liberado` = `pend_f0`.
  - Pulse `valido`, and pulse `carga` if not a release.
  - Clear both flags.
- `codigo`, `extendido` and `liberado` hold their values between events.

## Timing

- Reset (async assert, sync-safe release):
  - All outputs are 0.
  - FSM is in `REPOSO`; synchronizers and edge detector are at 1 (idle bus); counters and flags are cleared.
- Reset mid-frame: the partial frame is lost and no `error` is pulsed; the next start bit is received normally.
- Latency: let N be the first `clk` edge that samples the `clkps` pin low for the stop bit.
  - `valido` / `carga` / `error` are high for exactly the one cycle following edge N+2.
  - Data outputs change at edge N+2.
- A frame error and a valid event can never occur in the same cycle.
- A watchdog expiry coincident with a falling edge: the edge wins and the counter clears.
- `valido` pulses are spaced by at least one full PS/2 frame; no buffering is required.

## Configuration

- `PS2_PARITY_CHECK_EN` defined: the parity mismatch rule above is enforced and reported via `error`.
- Not defined:
  - The parity bit is still consumed (FSM passes through `PARIDAD`) but is ignored.
  - Only stop-bit and timeout errors pulse `error`.

## Test plan

1. Reset, then frame `1C` with parity 0 and stop 1 → one `valido` with `codigo`=`1C`, `extendido`=0, `liberado`=0, `carga`=1; `ocupado` low afterwards.
2. Frames `F0`, `1C` → exactly one `valido` with `codigo`=`1C`, `liberado`=1, `carga`=0; no event is produced for `F0`.
3. Frames `E0`, `75`, then `E0`, `F0`, `75` → first event `75` with `extendido`=1, `liberado`=0; second with `extendido`=1, `liberado`=1.
4. Frame `1C` with parity bit 1:
   - With `PS2_PARITY_CHECK_EN`: one `error` pulse, no `valido`, and a following `F0` `1C` still decodes as a release.
   - Without the macro: `valido` with `codigo`=`1C`.
5. Start bit plus 4 data bits, then `clkps` held high for `TIMEOUT_CYC` cycles → `error` pulse at the watchdog expiry and `ocupado` falls; the next full frame `29` decodes correctly.
6. `rst_n` asserted after 5 data bits of `16`, then released → all outputs 0 and no `error`; the next full frame `16` gives `valido` with `codigo`=`16`. Also, a stop bit of 0 on frame `16` → `error` pulse and no event.
